// File: rtl/video_stream_checker.sv
// Receive-side checker for the scaler video stream: rebuilds line/frame geometry, decodes trailer slot words
// and reports sticky per-frame protocol errors. Define VIDEO_CHECK_CRC_EN to add a per-frame CRC-16-CCITT of pixel data.
module video_stream_checker #(
  parameter int MAX_LINES = 1023
) (
  input  logic        clk_vid,
  input  logic        reset,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        de_in,
  input  logic [23:0] rgb_in,
  output logic [9:0]  line_width,
  output logic [2:0]  slot,
  output logic        line_224,
  output logic [9:0]  frame_lines,
  output logic        frame_valid,
  output logic        err_width,
  output logic        err_sync,
  output logic        err_word,
  output logic        err_lines,
  output logic [15:0] frame_crc
);

  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE, TRAILER} state_t;

  localparam logic [9:0] MAX_LINES_W = 10'(MAX_LINES);

  state_t      state_q, state_d;
  logic [9:0]  pix_cnt_q, pix_cnt_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [9:0]  line_width_q, line_width_d;
  logic [2:0]  slot_q, slot_d;
  logic        line_224_q, line_224_d;
  logic [9:0]  frame_lines_q, frame_lines_d;
  logic        frame_valid_q, frame_valid_d;
  logic        err_width_q, err_width_d;
  logic        err_sync_q, err_sync_d;
  logic        err_word_q, err_word_d;
  logic        err_lines_q, err_lines_d;
  logic        stk_width_q, stk_width_d;
  logic        stk_sync_q, stk_sync_d;
  logic        stk_word_q, stk_word_d;

  logic        frame_end, sync_now, word_ok, in_trailer, line_done;
  logic        word_err, width_err, l224_close;
  logic [2:0]  new_slot;
  logic [9:0]  exp_width, line_inc, lines_close;

  assign in_trailer  = (state_q == TRAILER);
  assign frame_end   = vsync_in && (state_q != IDLE);
  assign sync_now    = de_in && (vsync_in || hsync_in);
  assign word_ok     = (rgb_in[23:17] == 7'd0) && (rgb_in[12:0] == 13'd0);
  assign new_slot    = rgb_in[16:14];
  // A vsync cutting into ACTIVE still credits the partial line to the closing frame.
  assign line_done   = in_trailer || ((state_q == ACTIVE) && vsync_in);
  assign line_inc    = (line_cnt_q == MAX_LINES_W) ? line_cnt_q : line_cnt_q + 10'd1;
  assign lines_close = line_done ? line_inc : line_cnt_q;
  assign l224_close  = (in_trailer && word_ok) ? rgb_in[13] : line_224_q;
  assign word_err    = in_trailer && (!word_ok || (new_slot > 3'd2));
  assign width_err   = in_trailer && word_ok && (new_slot <= 3'd2) && (pix_cnt_q != exp_width);

  always_comb begin
    case (new_slot)
      3'd0:    exp_width = 10'd256;
      3'd1:    exp_width = 10'd360;
      default: exp_width = 10'd512;
    endcase
  end

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vsync_in) state_d = BLANK;
      BLANK:   if (de_in) state_d = ACTIVE;
      ACTIVE:  if (!de_in) state_d = vsync_in ? BLANK : TRAILER;
      TRAILER: state_d = de_in ? ACTIVE : BLANK;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_width_d  = line_width_q;
    slot_d        = slot_q;
    line_224_d    = line_224_q;
    frame_lines_d = frame_lines_q;
    frame_valid_d = 1'b0;
    err_width_d   = err_width_q;
    err_sync_d    = err_sync_q;
    err_word_d    = err_word_q;
    err_lines_d   = err_lines_q;
    stk_width_d   = stk_width_q;
    stk_sync_d    = stk_sync_q;
    stk_word_d    = stk_word_q;
    if (state_q != IDLE) begin
      if ((state_q == ACTIVE) && !vsync_in) begin
        if (de_in && (pix_cnt_q != 10'h3FF)) pix_cnt_d = pix_cnt_q + 10'd1;
      end else if (de_in) begin
        pix_cnt_d = 10'd1;
      end else if (frame_end) begin
        pix_cnt_d = '0;
      end
      if (in_trailer) begin
        line_width_d = pix_cnt_q;
        if (word_ok) begin
          slot_d     = new_slot;
          line_224_d = rgb_in[13];
        end
      end
      if (frame_end) begin
        frame_valid_d = 1'b1;
        frame_lines_d = lines_close;
        err_width_d   = stk_width_q | width_err;
        err_word_d    = stk_word_q | word_err;
        err_sync_d    = stk_sync_q | sync_now | (state_q == ACTIVE);
        err_lines_d   = lines_close != (l224_close ? 10'd224 : 10'd240);
        line_cnt_d    = '0;
        stk_width_d   = 1'b0;
        stk_sync_d    = 1'b0;
        stk_word_d    = 1'b0;
      end else begin
        if (line_done) line_cnt_d = line_inc;
        stk_width_d = stk_width_q | width_err;
        stk_sync_d  = stk_sync_q | sync_now;
        stk_word_d  = stk_word_q | word_err;
      end
    end
  end

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_width_q  <= '0;
      slot_q        <= '0;
      line_224_q    <= 1'b0;
      frame_lines_q <= '0;
      frame_valid_q <= 1'b0;
      err_width_q   <= 1'b0;
      err_sync_q    <= 1'b0;
      err_word_q    <= 1'b0;
      err_lines_q   <= 1'b0;
      stk_width_q   <= 1'b0;
      stk_sync_q    <= 1'b0;
      stk_word_q    <= 1'b0;
    end else begin
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_width_q  <= line_width_d;
      slot_q        <= slot_d;
      line_224_q    <= line_224_d;
      frame_lines_q <= frame_lines_d;
      frame_valid_q <= frame_valid_d;
      err_width_q   <= err_width_d;
      err_sync_q    <= err_sync_d;
      err_word_q    <= err_word_d;
      err_lines_q   <= err_lines_d;
      stk_width_q   <= stk_width_d;
      stk_sync_q    <= stk_sync_d;
      stk_word_q    <= stk_word_d;
    end
  end

  assign line_width  = line_width_q;
  assign slot        = slot_q;
  assign line_224    = line_224_q;
  assign frame_lines = frame_lines_q;
  assign frame_valid = frame_valid_q;
  assign err_width   = err_width_q;
  assign err_sync    = err_sync_q;
  assign err_word    = err_word_q;
  assign err_lines   = err_lines_q;

`ifdef VIDEO_CHECK_CRC_EN
  logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d, crc_base;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [23:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // The pixel sampled alongside a frame-ending vsync belongs to the new frame.
  always_comb begin
    crc_d       = crc_q;
    frame_crc_d = frame_crc_q;
    crc_base    = frame_end ? 16'hFFFF : crc_q;
    if (state_q != IDLE) begin
      crc_d = de_in ? crc_step(crc_base, rgb_in) : crc_base;
      if (frame_end) frame_crc_d = crc_q;
    end
  end

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      crc_q       <= 16'hFFFF;
      frame_crc_q <= '0;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_video_stream_checker.sv
// Scoreboard bench for video_stream_checker: stimulus tasks push expected line and frame reports,
// and the per-cycle monitor pops and compares them when the DUT presents them.
module tb_video_stream_checker;

   typedef struct {
      logic [9:0] width;
      logic [2:0] slotVal;
      logic       l224;
   } lineExp_t;

   typedef struct {
      logic [9:0]  lines;
      logic        errWidth;
      logic        errSync;
      logic        errWord;
      logic        errLines;
      logic [15:0] crc;
   } frameExp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        vsyncIn, hsyncIn, deIn;
   logic [23:0] rgbIn;
   logic [9:0]  lineWidth, frameLines;
   logic [2:0]  slotOut;
   logic        line224, frameValid, errWidth, errSync, errWord, errLines;
   logic [15:0] frameCrc;

   int checks = 0;
   int failures = 0;

   lineExp_t  lineQ[$];
   frameExp_t frameQ[$];

   // Bench-side bookkeeping of what the frame being built should report
   int          fLines;
   bit          fErrWidth, fErrSync, fErrWord;
   logic [2:0]  curSlot;
   bit          curL224;
   logic [15:0] crcRun;
   bit          started;

   video_stream_checker #(.MAX_LINES(1023)) dut (
      .clk_vid    (clock),
      .reset      (reset),
      .vsync_in   (vsyncIn),
      .hsync_in   (hsyncIn),
      .de_in      (deIn),
      .rgb_in     (rgbIn),
      .line_width (lineWidth),
      .slot       (slotOut),
      .line_224   (line224),
      .frame_lines(frameLines),
      .frame_valid(frameValid),
      .err_width  (errWidth),
      .err_sync   (errSync),
      .err_word   (errWord),
      .err_lines  (errLines),
      .frame_crc  (frameCrc)
   );

   // Free-running video clock, 10 time units per cycle
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports any disagreement
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   // Byte-at-a-time CRC-16-CCITT reference, MSB first
   function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   function automatic logic [15:0] crcPixel(input logic [15:0] c, input logic [23:0] p);
      return crcByte(crcByte(crcByte(c, p[23:16]), p[15:8]), p[7:0]);
   endfunction

   function automatic int expWidth(input logic [2:0] s);
      case (s)
         3'd0:    return 256;
         3'd1:    return 360;
         default: return 512;
      endcase
   endfunction

   // Start a fresh frame in the bench bookkeeping
   task automatic clearFrameBook();
      fLines    = 0;
      fErrWidth = 0;
      fErrSync  = 0;
      fErrWord  = 0;
      crcRun    = 16'hFFFF;
   endtask

   // Record what the DUT should report when the current frame closes
   task automatic pushFrame(input int linesClose, input bit extraSync);
      frameExp_t e;
      e.lines    = 10'(linesClose);
      e.errWidth = fErrWidth;
      e.errSync  = fErrSync | extraSync;
      e.errWord  = fErrWord;
      e.errLines = (linesClose != (curL224 ? 224 : 240));
`ifdef VIDEO_CHECK_CRC_EN
      e.crc      = crcRun;
`else
      e.crc      = 16'h0000;
`endif
      frameQ.push_back(e);
   endtask

   // Drive one clock cycle of inputs, then pop and compare whatever the DUT produced on that edge
   task automatic applyStimulus(input logic v, input logic h, input logic d, input logic [23:0] px, input bit isTrailer);
      lineExp_t  le;
      frameExp_t fe;
      vsyncIn = v;
      hsyncIn = h;
      deIn    = d;
      rgbIn   = px;
      @(posedge clock);
      #1;
      if (isTrailer) begin
         if (lineQ.size() == 0) checkOutput("line_queue_empty", 32'd1, 32'd0);
         else begin
            le = lineQ.pop_front();
            checkOutput("line_width", 32'(lineWidth), 32'(le.width));
            checkOutput("slot", 32'(slotOut), 32'(le.slotVal));
            checkOutput("line_224", 32'(line224), 32'(le.l224));
         end
      end
      if (frameValid) begin
         if (frameQ.size() == 0) checkOutput("frame_valid_spurious", 32'd1, 32'd0);
         else begin
            fe = frameQ.pop_front();
            checkOutput("frame_lines", 32'(frameLines), 32'(fe.lines));
            checkOutput("err_width", 32'(errWidth), 32'(fe.errWidth));
            checkOutput("err_sync", 32'(errSync), 32'(fe.errSync));
            checkOutput("err_word", 32'(errWord), 32'(fe.errWord));
            checkOutput("err_lines", 32'(errLines), 32'(fe.errLines));
            checkOutput("frame_crc", 32'(frameCrc), 32'(fe.crc));
         end
      end
   endtask

   // Vsync in blanking; closes a frame unless the checker is still waiting for its first vsync
   task automatic sendVsync();
      if (started) pushFrame(fLines, 1'b0);
      started = 1;
      clearFrameBook();
      applyStimulus(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
   endtask

   // One video line: pixels, a low-de cycle, the slot word, then blanking; optional hsync/vsync at a pixel index
   task automatic sendLine(input int width, input logic [23:0] word, input int hsyncAt, input int vsyncAt,
                           input bit zeroPix, input int gap);
      int          cnt;
      logic [23:0] px;
      lineExp_t    le;
      cnt = 0;
      for (int p = 0; p < width; p++) begin
         px = zeroPix ? 24'h0 : 24'($urandom);
         if (p == vsyncAt) begin
            pushFrame(fLines + 1, 1'b1);
            clearFrameBook();
            cnt = 0;
         end
         if (p == hsyncAt) fErrSync = 1;
         crcRun = crcPixel(crcRun, px);
         cnt++;
         applyStimulus(p == vsyncAt, p == hsyncAt, 1'b1, px, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
      if (word[23:17] == 7'd0 && word[12:0] == 13'd0) begin
         curSlot = word[16:14];
         curL224 = word[13];
         if (curSlot > 3'd2) fErrWord = 1;
         else if (cnt != expWidth(curSlot)) fErrWidth = 1;
      end else begin
         fErrWord = 1;
      end
      le.width   = 10'(cnt);
      le.slotVal = curSlot;
      le.l224    = curL224;
      lineQ.push_back(le);
      fLines++;
      applyStimulus(1'b0, 1'b0, 1'b0, word, 1'b1);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
   endtask

   // Every output must read zero while reset holds
   task automatic checkResetState();
      checkOutput("rst_line_width", 32'(lineWidth), 32'd0);
      checkOutput("rst_slot", 32'(slotOut), 32'd0);
      checkOutput("rst_line_224", 32'(line224), 32'd0);
      checkOutput("rst_frame_lines", 32'(frameLines), 32'd0);
      checkOutput("rst_frame_valid", 32'(frameValid), 32'd0);
      checkOutput("rst_err_width", 32'(errWidth), 32'd0);
      checkOutput("rst_err_sync", 32'(errSync), 32'd0);
      checkOutput("rst_err_word", 32'(errWord), 32'd0);
      checkOutput("rst_err_lines", 32'(errLines), 32'd0);
      checkOutput("rst_frame_crc", 32'(frameCrc), 32'd0);
   endtask

   // Main sequence: nominal frame, error frames, sync faults, CRC frame, back-to-back vsync, long frame, mid-frame reset
   initial begin
      reset   = 1'b1;
      vsyncIn = 1'b0;
      hsyncIn = 1'b0;
      deIn    = 1'b0;
      rgbIn   = 24'h0;
      started = 0;
      curSlot = 3'd0;
      curL224 = 0;
      clearFrameBook();
      repeat (3) @(posedge clock);
      #1;
      checkResetState();
      reset = 1'b0;

      $display("[TB] activity before the first vsync is ignored");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 24'($urandom), 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
      sendVsync();

      $display("[TB] nominal 224-line frame");
      for (int i = 0; i < 224; i++) sendLine(256, 24'h002000, -1, -1, 0, 1);
      sendVsync();

      $display("[TB] width mismatch and malformed slot words");
      sendLine(300, 24'h004000, -1, -1, 0, 1);
      sendLine(256, 24'h004001, -1, -1, 0, 1);
      sendLine(256, 24'h01C000, -1, -1, 0, 1);
      sendVsync();

      $display("[TB] hsync during active pixels");
      sendLine(256, 24'h000000, 100, -1, 0, 1);
      sendVsync();

      $display("[TB] vsync during active pixels");
      for (int i = 0; i < 5; i++) sendLine(256, 24'h000000, -1, -1, 0, 1);
      sendLine(256, 24'h000000, -1, 10, 0, 1);
      sendVsync();

      $display("[TB] single zero pixel frame, then a zero-line frame back to back");
      sendLine(1, 24'h002000, -1, -1, 1, 2);
      sendVsync();
      sendVsync();

      $display("[TB] 240 lines flagged as 224");
      for (int i = 0; i < 240; i++) sendLine(8, 24'h002000, -1, -1, 0, 1);
      sendVsync();

      $display("[TB] reset in the middle of a frame");
      for (int i = 0; i < 50; i++) sendLine(8, 24'h002000, -1, -1, 0, 1);
      reset = 1'b1;
      #2;
      checkResetState();
      @(posedge clock);
      #1;
      reset   = 1'b0;
      started = 0;
      curSlot = 3'd0;
      curL224 = 0;
      clearFrameBook();
      applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
      sendVsync();
      sendLine(256, 24'h000000, -1, -1, 0, 1);
      sendLine(256, 24'h000000, -1, -1, 0, 1);
      sendVsync();
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);

      checkOutput("frames_pending", 32'(frameQ.size()), 32'd0);
      checkOutput("lines_pending", 32'(lineQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/video_stream_checker.md
# video_stream_checker

Receive-side decoder for the scaler-facing video stream the core produces: one-cycle vsync and hsync pulses, `de`-qualified 24-bit pixels, and a slot word on `rgb` in the cycle after each `de` falling edge. It sits on `clk_vid` beside the video output path, or in the bench, and reconstructs per-line and per-frame geometry. It decodes the slot word and raises sticky per-frame protocol errors, so framing faults are caught without a scaler attached.

## Interface
Parameters:
- `MAX_LINES`, 1023: saturation value for the line counter.

Ports:
- `clk_vid` in 1: video clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `vsync_in` in 1: one-cycle frame-start pulse.
- `hsync_in` in 1: one-cycle line-start pulse.
- `de_in` in 1: pixel valid.
- `rgb_in` in 24: pixel data, or the slot word in the cycle after `de_in` falls.
- `line_width` out 10: `de` cycle count of the last completed line.
- `slot` out 3: slot field of the last valid slot word.
- `line_224` out 1: 224-line flag of the last valid slot word.
- `frame_lines` out 10: lines with `de` in the last completed frame.
- `frame_valid` out 1: one-cycle pulse when the frame outputs update.
- `err_width` out 1: frame error, a line width did not match the slot.
- `err_sync` out 1: frame error, vsync or hsync occurred while `de` was high.
- `err_word` out 1: frame error, malformed slot word.
- `err_lines` out 1: frame error, line count did not match `line_224`.
- `frame_crc` out 16: CRC of the last frame's pixels (see Configuration).

## Operation
- **States:**
  - IDLE: waiting for the first vsync.
  - BLANK: between lines.
  - ACTIVE: `de` high.
  - TRAILER: the single cycle after `de` falls.
- **Transitions:**
  - IDLE→BLANK on `vsync_in`. All other inputs are ignored in IDLE.
  - BLANK→ACTIVE on `de_in`=1. A pixel counter loads 1.
  - ACTIVE: the counter increments while `de_in`=1, saturating at 1023. On `de_in`=0 go to TRAILER.
  - TRAILER: decode `rgb_in`, then go to BLANK. If `de_in`=1 in this cycle, decode anyway and go directly to ACTIVE with the counter at 1.
- **Slot word:**
  - The word is valid iff `rgb_in[23:17]`=0 and `rgb_in[12:0]`=0.
  - Valid: `slot`←`rgb_in[16:14]`, `line_224`←`rgb_in[13]`.
  - Invalid: set `err_word`; `slot` and `line_224` hold.
- **Expected width:** slot 0→256, 1→360, 2→512.
  - Slot 3–7 sets `err_word`.
  - A mismatch between the pixel count and the expected width sets `err_width`.
  - `line_width`←pixel count and the line counter increments (saturating at `MAX_LINES`) at TRAILER.
- **Sync check:** `vsync_in` or `hsync_in` sampled with `de_in`=1 sets `err_sync`. The pixel is still counted.
- **Frame end:** `vsync_in` in BLANK, ACTIVE or TRAILER ends the frame.
  - Latch `frame_lines`, the four error flags and `frame_crc`.
  - Set `err_lines` if the line count ≠ (`line_224` ? 224 : 240).
  - Clear the internal counters and sticky flags.
  - A vsync arriving in ACTIVE also sets `err_sync` for the frame being closed. The partial line is counted, and the machine goes to ACTIVE for the new frame.
  - A frame with zero lines still reports, with `err_lines`=1.
- **Simultaneous vsync and TRAILER:** the trailer decode and its line are credited to the closing frame first.

## Timing
- Reset: every output is 0, the state is IDLE and the counters are 0. Reset asserted mid-frame discards that frame, with no `frame_valid`.
- `line_width`, `slot` and `line_224` update on the clock edge that samples the TRAILER cycle, so they are visible one cycle after TRAILER.
- The frame outputs and `frame_valid` assert on the edge that samples `vsync_in`, so they are visible the next cycle. `frame_valid` is high exactly one cycle.
- The frame outputs hold until the next frame end.
- Back-to-back vsync pulses each report a frame.

## Configuration
- `VIDEO_CHECK_CRC_EN` defined:
  - CRC-16-CCITT (polynomial 0x1021, seed 0xFFFF, no reflection, no final XOR).
  - Computes one 24-bit step per `de` cycle over `rgb_in[23:0]`, MSB first.
  - Reseeded at each frame end; the running value is latched into `frame_crc`.
- Undefined: the CRC logic is absent and `frame_crc` is tied to 0.

## Test plan
- **Nominal 224-line frame:** vsync, then 224 lines of 256 `de` cycles, each followed by slot word 0x002000, then vsync → `frame_valid` pulse, `frame_lines`=224, `slot`=0, `line_224`=1, all errors 0.
- **Width mismatch:** one line of 300 pixels with slot word 0x004000 (slot 1 → 360) → `err_width`=1 in the next report, `line_width`=300.
- **Malformed word:** trailer 0x004001 → `err_word`=1, `slot` unchanged. Trailer 0x01C000 (slot 7) → `err_word`=1.
- **Sync during active pixels:**
  - hsync pulse at pixel 100 of a 256-pixel line → `err_sync`=1, `line_width`=256.
  - vsync at pixel 10 → the frame closes with `err_sync`=1 and the next frame starts in ACTIVE.
- **Line count:** 240 lines with `line_224`=1 → `err_lines`=1, `frame_lines`=240. `reset` pulsed at line 50 → all outputs 0 and no `frame_valid` until the second vsync after reset.
- **CRC (macro defined):** a frame containing a single pixel 0x000000 → `frame_crc` equals a golden-model CRC of three zero bytes from seed 0xFFFF. With the macro undefined → `frame_crc`=0.
